fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Generic FIFO: head-of-queue storage with synchronous flush; DEPTH must be a power of two.
// Latency: a pushed entry is visible at head_dat the cycle after the push edge.
// Backpressure: none internally; the caller never pushes when full unless it also pops.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop_rdy,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    assign head_dat = mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the queue in one edge.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + AW'(1);
            if (pop_rdy)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_vld) - CW'(pop_rdy);
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end
endmodule

// Instruction fetch: keeps a 2-entry {addr, instr} buffer topped up from instruction memory.
// Latency: zero-wait memory presents an instruction one cycle after its request; redirect costs two.
// Backpressure: Stall holds the head; requests stop while both entries are occupied.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] Result,
    input  logic        Stall,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRData,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8
);
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {FETCH, FULL, DROP} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [31:0]  fetch_pc;
    logic [31:0]  fetch_pc_nxt;
    logic [31:0]  redir_pc;
    logic [31:0]  redir_pc_nxt;
    logic [31:0]  target;
    logic [1:0]   count;
    logic [1:0]   count_nxt;
    logic         push;
    logic         pop;
    logic         take;
    fetch_entry_t push_ent;
    fetch_entry_t head_ent;
    logic         unused_result_lsbs;

    // Redirect targets are word aligned; the low bits of Result carry no meaning here.
    assign target             = {Result[31:2], 2'b00};
    assign unused_result_lsbs = ^Result[1:0];

    assign InstrValid = (count != 2'd0);
    assign pop        = InstrValid && !Stall;
    // A redirect only counts when the branch instruction itself is being consumed.
    assign take       = pop && PCSrc;
    // Data returning in a redirect cycle belongs to the abandoned path and is dropped.
    assign push       = (state == FETCH) && IMemAck && !take;
    assign push_ent   = '{addr: fetch_pc, instr: IMemRData};
    assign count_nxt  = take ? 2'd0 : (count + {1'b0, push} - {1'b0, pop});

    // In DROP the address stays on fetch_pc so the outstanding request is held stable.
    assign IMemReq  = (state != FULL);
    assign IMemAddr = fetch_pc;

    assign Instr   = InstrValid ? head_ent.instr : 32'h0;
    assign PC      = InstrValid ? head_ent.addr  : 32'h0;
    assign PCPlus8 = PC + 32'd8;

    fetch_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (2)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .flush    (take),
        .push_vld (push),
        .push_dat (push_ent),
        .pop_rdy  (pop),
        .head_dat (head_ent),
        .count    (count)
    );

    // Fetch state, fetch address and pending redirect target registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            redir_pc <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            redir_pc <= redir_pc_nxt;
        end
    end

    // Next-state logic: one request in flight at most; DROP waits out a request made stale by a redirect.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        redir_pc_nxt = redir_pc;
        case (state)
            FETCH: begin
                if (take) begin
                    if (IMemAck) begin
                        fetch_pc_nxt = target;
                    end else begin
                        redir_pc_nxt = target;
                        state_nxt    = DROP;
                    end
                end else begin
                    if (IMemAck) fetch_pc_nxt = fetch_pc + 32'd4;
                    if (count_nxt == 2'd2) state_nxt = FULL;
                end
            end
            FULL: begin
                if (take) begin
                    fetch_pc_nxt = target;
                    state_nxt    = FETCH;
                end else if (count_nxt < 2'd2) begin
                    state_nxt = FETCH;
                end
            end
            DROP: begin
                if (take) redir_pc_nxt = target;
                if (IMemAck) begin
                    fetch_pc_nxt = take ? target : redir_pc;
                    state_nxt    = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed stimulus with a scoreboard of consumed instructions.
// Latency: memory model acks after a programmable number of wait cycles.
// Backpressure: Stall driven directly from the stimulus sequence.
module tb_fetch_unit;
    logic        clk;
    logic        reset;
    logic        PCSrc;
    logic [31:0] Result;
    logic        Stall;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemRData;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus8;

    logic        IMemReq2;
    logic [31:0] IMemAddr2;
    logic [31:0] IMemRData2;
    logic [31:0] Instr2;
    logic        InstrValid2;
    logic [31:0] PC2;
    logic [31:0] PCPlus8_2;

    int n_cmp = 0;
    int n_bad = 0;
    int lat = 0;
    int wait_cnt = 0;

    typedef logic [31:0] addr_t;
    addr_t exp_q[$];
    addr_t exp2_q[$];

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .PCSrc      (PCSrc),
        .Result     (Result),
        .Stall      (Stall),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemAck    (IMemAck),
        .IMemRData  (IMemRData),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .PC         (PC),
        .PCPlus8    (PCPlus8)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .PCSrc      (1'b0),
        .Result     (32'h0),
        .Stall      (1'b0),
        .IMemReq    (IMemReq2),
        .IMemAddr   (IMemAddr2),
        .IMemAck    (IMemReq2),
        .IMemRData  (IMemRData2),
        .Instr      (Instr2),
        .InstrValid (InstrValid2),
        .PC         (PC2),
        .PCPlus8    (PCPlus8_2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: ack after lat wait cycles, data is the address scrambled with a fixed pattern.
    assign IMemAck    = IMemReq && (wait_cnt == lat);
    assign IMemRData  = IMemAddr ^ 32'hA5A5_0000;
    assign IMemRData2 = IMemAddr2 ^ 32'hA5A5_0000;

    always @(posedge clk) begin
        if (reset)                   wait_cnt <= 0;
        else if (IMemReq && !IMemAck) wait_cnt <= wait_cnt + 1;
        else                         wait_cnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pc(input logic [31:0] target);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step();
            if (InstrValid === 1'b1 && PC === target) hit = 1'b1;
        end
        if (!hit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_pc: PC %h never presented, expected %h", PC, target);
        end
    endtask

    // Scoreboard monitor for the main instance: every consumed instruction must be next in line.
    initial begin
        addr_t e;
        forever begin
            @(negedge clk);
            if (InstrValid === 1'b1 && Stall === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got PC %h, expected no instruction", PC);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", PC, e);
                    chk("sb_instr", Instr, e ^ 32'hA5A5_0000);
                    chk("sb_pcplus8", PCPlus8, e + 32'd8);
                end
            end
        end
    end

    // Monitor for the wrap-around instance; only its first few instructions are of interest.
    initial begin
        addr_t e;
        forever begin
            @(negedge clk);
            if (InstrValid2 === 1'b1 && exp2_q.size() != 0) begin
                e = exp2_q.pop_front();
                chk("wrap_pc", PC2, e);
                chk("wrap_instr", Instr2, e ^ 32'hA5A5_0000);
                chk("wrap_pcplus8", PCPlus8_2, e + 32'd8);
            end
        end
    end

    initial begin
        reset  = 1'b1;
        PCSrc  = 1'b0;
        Result = 32'h0;
        Stall  = 1'b0;
        lat    = 0;

        // Consumption order across the whole run.
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        exp_q.push_back(32'h0000_0008);
        exp_q.push_back(32'h0000_0100);
        exp_q.push_back(32'h0000_0104);
        exp_q.push_back(32'h0000_0108);
        exp_q.push_back(32'h0000_0200);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        exp2_q.push_back(32'hFFFF_FFF8);
        exp2_q.push_back(32'hFFFF_FFFC);
        exp2_q.push_back(32'h0000_0000);

        // Reset state, with the memory acking during reset.
        step();
        step();
        @(negedge clk);
        chk("rst_valid", {31'b0, InstrValid}, 32'd0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_pcplus8", PCPlus8, 32'd8);
        chk("rst_req", {31'b0, IMemReq}, 32'd1);
        chk("rst_addr", IMemAddr, 32'h0);
        chk("rst_addr2", IMemAddr2, 32'hFFFF_FFF8);
        chk("rst_pcplus8_2", PCPlus8_2, 32'd8);

        // Zero-wait streaming: request cycle then valid on the next one.
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("lat_req_cycle_valid", {31'b0, InstrValid}, 32'd0);
        step();
        @(negedge clk);
        chk("lat_next_cycle_valid", {31'b0, InstrValid}, 32'd1);
        chk("lat_next_cycle_pc", PC, 32'h0);

        // Redirect at PC 8 to an unaligned target.
        wait_pc(32'h0000_0008);
        PCSrc  = 1'b1;
        Result = 32'h0000_0103;
        step();
        PCSrc  = 1'b0;
        Result = 32'h0;
        @(negedge clk);
        chk("redir_gap_valid", {31'b0, InstrValid}, 32'd0);
        chk("redir_target_addr", IMemAddr, 32'h0000_0100);

        // Stall four cycles from one buffered entry.
        step();
        Stall = 1'b1;
        @(negedge clk);
        chk("redir_arrive_pc", PC, 32'h0000_0100);
        step();
        @(negedge clk);
        chk("full_req", {31'b0, IMemReq}, 32'd0);
        step();
        step();
        @(negedge clk);
        chk("full_hold_pc", PC, 32'h0000_0100);
        chk("full_hold_req", {31'b0, IMemReq}, 32'd0);
        step();
        Stall = 1'b0;
        step();
        Stall = 1'b1;
        @(negedge clk);
        chk("resume_addr", IMemAddr, 32'h0000_0108);
        chk("resume_req", {31'b0, IMemReq}, 32'd1);
        chk("resume_head", PC, 32'h0000_0104);

        // Slow memory: redirect while a request is outstanding.
        step();
        lat = 3;
        @(negedge clk);
        chk("refill_full_req", {31'b0, IMemReq}, 32'd0);
        step();
        Stall = 1'b0;
        step();
        PCSrc  = 1'b1;
        Result = 32'h0000_0200;
        @(negedge clk);
        chk("slow_req_addr", IMemAddr, 32'h0000_010C);
        chk("slow_head", PC, 32'h0000_0108);
        step();
        PCSrc  = 1'b0;
        Result = 32'h0;
        @(negedge clk);
        chk("drop_req", {31'b0, IMemReq}, 32'd1);
        chk("drop_addr", IMemAddr, 32'h0000_010C);
        chk("drop_valid", {31'b0, InstrValid}, 32'd0);
        step();
        step();
        @(negedge clk);
        chk("drop_ack_addr", IMemAddr, 32'h0000_010C);
        step();
        @(negedge clk);
        chk("drop_exit_addr", IMemAddr, 32'h0000_0200);
        chk("drop_exit_valid", {31'b0, InstrValid}, 32'd0);

        // Enter DROP again, then reset on top of a redirect.
        wait_pc(32'h0000_0200);
        PCSrc  = 1'b1;
        Result = 32'h0000_0300;
        step();
        @(negedge clk);
        chk("drop2_addr", IMemAddr, 32'h0000_0204);
        step();
        reset = 1'b1;
        lat   = 0;
        step();
        reset  = 1'b0;
        PCSrc  = 1'b0;
        Result = 32'h0;
        @(negedge clk);
        chk("postrst_valid", {31'b0, InstrValid}, 32'd0);
        chk("postrst_addr", IMemAddr, 32'h0);
        chk("postrst_req", {31'b0, IMemReq}, 32'd1);

        wait_pc(32'h0000_0008);
        Stall = 1'b1;
        step();
        step();
        step();
        @(negedge clk);
        chk("final_hold_pc", PC, 32'h0000_0008);
        chk("sb_left_main", exp_q.size(), 32'd0);
        chk("sb_left_wrap", exp2_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
